regfile_mp: RTL and testbench



---
 rtl/regfile_mp_pkg.sv | 19 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp_mux_nw.sv | 24 ++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
// The defaults describe the LEGv8 64-bit, 32-entry register set with XZR at index 31.
package regfile_pkg;

  localparam int REGFILE_WIDTH_DEF = 64;
  localparam int REGFILE_DEPTH_DEF = 32;
  localparam int XZR_IDX           = 31;

  // Address width needed to index 'depth' entries (ceil(log2(depth))).
  function automatic int regfile_aw(input int depth);
    int aw;
    aw = 0;
    for (int v = depth - 1; v > 0; v = v >>> 1) begin
      aw++;
    end
    return aw;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write-port and read-port bundle of the register file.
// The pipeline side uses the master view; the register file uses the slave view.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REGFILE_WIDTH_DEF,
  parameter int AW     = regfile_aw(REGFILE_DEPTH_DEF),
  parameter int NUM_RD = 2
);

  logic                               wr_en;
  logic [AW-1:0]                      wr_addr;
  logic [WIDTH-1:0]                   wr_data;
  logic [NUM_RD-1:0][AW-1:0]          rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]       rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/regfile_mp_mux_nw.sv
// N:1 selector of WIDTH-bit words.
// A select value at or beyond N yields zero instead of an undefined word.
module mux_nw
  import regfile_pkg::*;
#(
  parameter  int WIDTH = REGFILE_WIDTH_DEF,
  parameter  int N     = REGFILE_DEPTH_DEF,
  localparam int SW    = regfile_aw(N)
) (
  input  logic [N-1:0][WIDTH-1:0] data_i,
  input  logic [SW-1:0]           sel_i,
  output logic [WIDTH-1:0]        data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SW'(i)) begin
        data_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one synchronous write port, NUM_RD read ports, hardwired
// zero register, optional write-to-read bypass and optional registered read data.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH_DEF,
  parameter int DEPTH    = REGFILE_DEPTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = XZR_IDX,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_READ = 1'b0
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam int AW = regfile_aw(DEPTH);

  if (DEPTH < 2) begin : g_chkDepth
    $error("regfile_mp: DEPTH must be at least 2");
  end
  if (NUM_RD < 1) begin : g_chkNumRd
    $error("regfile_mp: NUM_RD must be at least 1");
  end
  if ((ZERO_REG < 0) || (ZERO_REG >= DEPTH)) begin : g_chkZeroReg
    $error("regfile_mp: ZERO_REG must index an existing register");
  end

  logic                         wrValid;
  logic [DEPTH-1:0][WIDTH-1:0]  memArr_q;
  logic [DEPTH-1:0][WIDTH-1:0]  memArr_d;
  logic [NUM_RD-1:0][WIDTH-1:0] muxOut;
  logic [NUM_RD-1:0][WIDTH-1:0] readVal_d;

  // Writes to the zero register or past the last entry are silently dropped.
  assign wrValid = bus.wr_en && !reset
                   && (bus.wr_addr != AW'(ZERO_REG))
                   && (int'(bus.wr_addr) < DEPTH);

  always_comb begin
    memArr_d = memArr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wrValid && (bus.wr_addr == AW'(i))) begin
        memArr_d[i] = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memArr_q <= '0;
    end else begin
      memArr_q <= memArr_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rdMux
    mux_nw #(
      .WIDTH (WIDTH),
      .N     (DEPTH)
    ) u_mux (
      .data_i (memArr_q),
      .sel_i  (bus.rd_addr[p]),
      .data_o (muxOut[p])
    );
  end

  // Zero/out-of-range masking outranks the bypass, which is suppressed during reset.
  always_comb begin
    readVal_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((bus.rd_addr[p] == AW'(ZERO_REG)) || (int'(bus.rd_addr[p]) >= DEPTH)) begin
        readVal_d[p] = '0;
      end else if (BYPASS && bus.wr_en && !reset && (bus.wr_addr == bus.rd_addr[p])) begin
        readVal_d[p] = bus.wr_data;
      end else begin
        readVal_d[p] = muxOut[p];
      end
    end
  end

  if (REG_READ) begin : g_regRead
    logic [NUM_RD-1:0][WIDTH-1:0] rdData_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rdData_q <= '0;
      end else begin
        rdData_q <= readVal_d;
      end
    end

    assign bus.rd_data = rdData_q;
  end else begin : g_combRead
    assign bus.rd_data = readVal_d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: four configurations share one stimulus stream and a
// negedge monitor pops the expected read values queued for the current cycle.
module tb_regfile_mp;

  localparam int DUT_A = 0;  // bypass, combinational read
  localparam int DUT_B = 1;  // no bypass, combinational read
  localparam int DUT_C = 2;  // bypass, registered read
  localparam int DUT_D = 3;  // DEPTH=24, NUM_RD=3, zero register 23

  localparam logic [63:0] V5   = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] ONES = '1;

  typedef struct {
    int          dut;
    int          port;
    int          cyc;
    logic [63:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cycleCnt;
  int   checksTotal;
  int   checksPassed;
  exp_t sbQ[$];

  regfile_mp_if #(.WIDTH(64), .AW(5), .NUM_RD(2)) ifA ();
  regfile_mp_if #(.WIDTH(64), .AW(5), .NUM_RD(2)) ifB ();
  regfile_mp_if #(.WIDTH(64), .AW(5), .NUM_RD(2)) ifC ();
  regfile_mp_if #(.WIDTH(64), .AW(5), .NUM_RD(3)) ifD ();

  regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1'b1), .REG_READ(1'b0))
    dutA (.clk(clk), .reset(reset), .bus(ifA));
  regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1'b0), .REG_READ(1'b0))
    dutB (.clk(clk), .reset(reset), .bus(ifB));
  regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(31), .BYPASS(1'b1), .REG_READ(1'b1))
    dutC (.clk(clk), .reset(reset), .bus(ifC));
  regfile_mp #(.WIDTH(64), .DEPTH(24), .NUM_RD(3), .ZERO_REG(23), .BYPASS(1'b1), .REG_READ(1'b0))
    dutD (.clk(clk), .reset(reset), .bus(ifD));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Drives one cycle of inputs just after the rising edge to every configuration.
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                               input logic [63:0] wd, input logic [4:0] r0,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    reset = rst;
    ifA.wr_en = we; ifA.wr_addr = wa; ifA.wr_data = wd; ifA.rd_addr[0] = r0; ifA.rd_addr[1] = r1;
    ifB.wr_en = we; ifB.wr_addr = wa; ifB.wr_data = wd; ifB.rd_addr[0] = r0; ifB.rd_addr[1] = r1;
    ifC.wr_en = we; ifC.wr_addr = wa; ifC.wr_data = wd; ifC.rd_addr[0] = r0; ifC.rd_addr[1] = r1;
    ifD.wr_en = we; ifD.wr_addr = wa; ifD.wr_data = wd;
    ifD.rd_addr[0] = r0; ifD.rd_addr[1] = r1; ifD.rd_addr[2] = r2;
  endtask

  // Queues an expected read value, due 'off' cycles after the current stimulus cycle.
  task automatic checkOutput(input int dut, input int port, input int off,
                             input logic [63:0] val, input string name);
    exp_t e;
    e.dut  = dut;
    e.port = port;
    e.cyc  = cycleCnt + off;
    e.exp  = val;
    e.name = name;
    sbQ.push_back(e);
  endtask

  function automatic logic [63:0] actualOf(input int dut, input int port);
    case (dut)
      DUT_A:   return ifA.rd_data[port];
      DUT_B:   return ifB.rd_data[port];
      DUT_C:   return ifC.rd_data[port];
      default: return ifD.rd_data[port];
    endcase
  endfunction

  // Negedge monitor: compares every queued expectation that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sbQ.size() - 1; i >= 0; i--) begin
      if (sbQ[i].cyc == cycleCnt) begin
        logic [63:0] act;
        act = actualOf(sbQ[i].dut, sbQ[i].port);
        checksTotal++;
        if (act !== sbQ[i].exp) begin
          $display("[TB] FAIL %s dut=%0d port=%0d cycle=%0d got=%h expected=%h",
                   sbQ[i].name, sbQ[i].dut, sbQ[i].port, cycleCnt, act, sbQ[i].exp);
        end else begin
          checksPassed++;
        end
        sbQ.delete(i);
      end
    end
  end

  // Watchdog guarding against a hung simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence following the test plan.
  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    reset = 1'b1;
    ifA.wr_en = 1'b0; ifA.wr_addr = '0; ifA.wr_data = '0; ifA.rd_addr = '0;
    ifB.wr_en = 1'b0; ifB.wr_addr = '0; ifB.wr_data = '0; ifB.rd_addr = '0;
    ifC.wr_en = 1'b0; ifC.wr_addr = '0; ifC.wr_data = '0; ifC.rd_addr = '0;
    ifD.wr_en = 1'b0; ifD.wr_addr = '0; ifD.wr_data = '0; ifD.rd_addr = '0;

    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0);
    checkOutput(DUT_C, 0, 1, 64'h0, "reg_reset_clear");

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), 5'(i));
      checkOutput(DUT_A, 0, 0, 64'h0, "reset_sweep");
    end

    applyStimulus(1'b0, 1'b1, 5'd5, V5, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd6, 5'd5);
    checkOutput(DUT_A, 0, 0, V5,    "basic_p0");
    checkOutput(DUT_A, 1, 0, 64'h0, "basic_p1_unwritten");
    checkOutput(DUT_B, 0, 0, V5,    "basic_nobyp");
    checkOutput(DUT_D, 0, 0, V5,    "basic_d_p0");
    checkOutput(DUT_D, 2, 0, V5,    "basic_d_p2");
    checkOutput(DUT_C, 0, 1, V5,    "basic_reg");
    @(negedge clk);
    checksTotal++;
    if (ifA.rd_data[0] !== V5) begin
      $display("[TB] FAIL direct_basic_p0 got=%h expected=%h", ifA.rd_data[0], V5);
    end else begin
      checksPassed++;
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 5'd5);
    checkOutput(DUT_A, 0, 0, V5, "same_addr_p0");
    checkOutput(DUT_A, 1, 0, V5, "same_addr_p1");
    @(negedge clk);
    checksTotal++;
    if ((ifA.rd_data[0] !== V5) || (ifA.rd_data[1] !== V5)) begin
      $display("[TB] FAIL direct_same_addr got=%h/%h expected=%h",
               ifA.rd_data[0], ifA.rd_data[1], V5);
    end else begin
      checksPassed++;
    end

    applyStimulus(1'b0, 1'b1, 5'd7, 64'h11, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 64'h1234, 5'd0, 5'd7, 5'd7);
    checkOutput(DUT_A, 1, 0, 64'h1234, "bypass_new");
    checkOutput(DUT_A, 0, 0, 64'h0,    "bypass_other_port");
    checkOutput(DUT_B, 1, 0, 64'h11,   "nobypass_old");
    checkOutput(DUT_D, 2, 0, 64'h1234, "bypass_d_p2");
    checkOutput(DUT_C, 1, 1, 64'h1234, "reg_bypass_no_stale");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd7, 5'd7);
    checkOutput(DUT_B, 1, 0, 64'h1234, "nobypass_next_cycle");
    checkOutput(DUT_A, 1, 0, 64'h1234, "bypass_stored");

    applyStimulus(1'b0, 1'b1, 5'd31, ONES, 5'd31, 5'd31, 5'd31);
    checkOutput(DUT_A, 0, 0, 64'h0, "xzr_bypass_p0");
    checkOutput(DUT_A, 1, 0, 64'h0, "xzr_bypass_p1");
    checkOutput(DUT_B, 0, 0, 64'h0, "xzr_nobyp");
    checkOutput(DUT_C, 0, 1, 64'h0, "xzr_reg");
    checkOutput(DUT_D, 2, 0, 64'h0, "d_out_of_range_31");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31, 5'd31);
    checkOutput(DUT_A, 0, 0, 64'h0, "xzr_after_write");
    checkOutput(DUT_B, 1, 0, 64'h0, "xzr_after_write_b");
    checkOutput(DUT_D, 2, 0, 64'h0, "d_oor_after_write");

    applyStimulus(1'b0, 1'b1, 5'd23, 64'hABC, 5'd23, 5'd0, 5'd23);
    checkOutput(DUT_A, 0, 0, 64'hABC, "x23_bypass");
    checkOutput(DUT_B, 0, 0, 64'h0,   "x23_nobyp_old");
    checkOutput(DUT_D, 0, 0, 64'h0,   "d_zero_reg_bypass_p0");
    checkOutput(DUT_D, 2, 0, 64'h0,   "d_zero_reg_bypass_p2");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd23, 5'd0, 5'd23);
    checkOutput(DUT_A, 0, 0, 64'hABC, "x23_stored");
    checkOutput(DUT_B, 0, 0, 64'hABC, "x23_stored_b");
    checkOutput(DUT_D, 0, 0, 64'h0,   "d_zero_reg_stored");

    applyStimulus(1'b0, 1'b1, 5'd30, 64'h3030, 5'd30, 5'd0, 5'd30);
    checkOutput(DUT_A, 0, 0, 64'h3030, "x30_bypass");
    checkOutput(DUT_D, 0, 0, 64'h0,    "d_addr30_bypass_p0");
    checkOutput(DUT_D, 2, 0, 64'h0,    "d_addr30_bypass_p2");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd30, 5'd30, 5'd30);
    checkOutput(DUT_A, 0, 0, 64'h3030, "x30_stored_p0");
    checkOutput(DUT_A, 1, 0, 64'h3030, "x30_stored_p1");
    checkOutput(DUT_D, 2, 0, 64'h0,    "d_addr30_read");

    applyStimulus(1'b0, 1'b1, 5'd3, 64'hA5, 5'd3, 5'd0, 5'd3);
    checkOutput(DUT_C, 0, 0, 64'h3030, "reg_latency_prev");
    checkOutput(DUT_C, 0, 1, 64'hA5,   "reg_latency_new");
    checkOutput(DUT_A, 0, 0, 64'hA5,   "x3_bypass");
    checkOutput(DUT_B, 0, 0, 64'h0,    "x3_nobyp_old");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd0, 5'd3);
    checkOutput(DUT_B, 0, 0, 64'hA5, "x3_nobyp_next");
    checkOutput(DUT_C, 0, 1, 64'hA5, "reg_stored");

    applyStimulus(1'b0, 1'b1, 5'd9, 64'h55, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd9, 64'h77, 5'd9, 5'd5, 5'd9);
    checkOutput(DUT_A, 0, 0, 64'h55, "reset_bypass_suppressed");
    checkOutput(DUT_B, 0, 0, 64'h55, "reset_cycle_old_b");
    checkOutput(DUT_D, 2, 0, 64'h55, "reset_bypass_suppressed_d");
    checkOutput(DUT_C, 0, 1, 64'h0,  "reg_reset_p0");
    checkOutput(DUT_C, 1, 1, 64'h0,  "reg_reset_p1");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd5, 5'd9);
    checkOutput(DUT_A, 0, 0, 64'h0, "x9_after_reset");
    checkOutput(DUT_A, 1, 0, 64'h0, "x5_after_reset");
    checkOutput(DUT_B, 0, 0, 64'h0, "x9_after_reset_b");
    checkOutput(DUT_D, 2, 0, 64'h0, "x9_after_reset_d");
    checkOutput(DUT_C, 0, 1, 64'h0, "x9_after_reset_reg");
    @(negedge clk);
    checksTotal++;
    if (ifA.rd_data[0] !== 64'h0) begin
      $display("[TB] FAIL direct_x9_after_reset got=%h expected=0", ifA.rd_data[0]);
    end else begin
      checksPassed++;
    end

    applyStimulus(1'b1, 1'b1, 5'd31, ONES, 5'd31, 5'd31, 5'd31);
    checkOutput(DUT_A, 0, 0, 64'h0, "xzr_reset_write");
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd0, 5'd31);
    checkOutput(DUT_A, 0, 0, 64'h0, "xzr_after_reset_write");
    checkOutput(DUT_C, 0, 1, 64'h0, "xzr_after_reset_write_reg");

    repeat (3) @(posedge clk);
    #1;
    foreach (sbQ[i]) begin
      checksTotal++;
      $display("[TB] FAIL %s dut=%0d port=%0d got=no_sample expected=%h",
               sbQ[i].name, sbQ[i].dut, sbQ[i].port, sbQ[i].exp);
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
